// File: rtl/config_readback_pkg.sv
// Shared definitions for the configuration readback block: register map,
// STATUS bit positions, capture FSM states and the CRC-16/CCITT constants.
package config_readback_pkg;

  // Register offsets from the base address
  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_DATA   = 4'h8;
  localparam logic [3:0] OFS_CRC    = 4'hC;

  // CTRL fields
  localparam int CTRL_START_BIT = 31;

  // STATUS bit indices
  localparam int ST_BUSY          = 0;
  localparam int ST_DONE          = 1;
  localparam int ST_ERR_START     = 2;
  localparam int ST_ERR_UNDERFLOW = 3;
  localparam int ST_LEVEL_LSB     = 4;

  // CRC-16/CCITT
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // One serial step of the CRC, MSB-first feedback
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/config_readback_fifo.sv
// Small synchronous word FIFO with full/empty flags and an occupancy count.
// A push into a full FIFO is accepted only when a pop frees the slot in the
// same cycle; a pop from an empty FIFO is ignored.
module config_readback_fifo
  import config_readback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/config_readback.sv
// Wishbone slave capturing the configuration chain scan-out into 32-bit words.
// Optional feature: define CONFIG_READBACK_CRC_EN to add a CRC-16/CCITT over
// the captured bit stream; otherwise the CRC register reads 0.
module config_readback
  import config_readback_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_1000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        shift_in,
  output logic        shift_enable_o,
  output logic        busy_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  state_t          state_next;
  logic [15:0]     ctrl_n;
  logic            start_req;
  logic            busy_q;
  logic            done;
  logic            err_start;
  logic            err_underflow;
  logic [15:0]     remaining;
  logic [4:0]      bitpos;
  logic [31:0]     acc;
  logic [31:0]     acc_with_bit;
  logic            push_due;
  logic            take_bit;
  logic            accept_start;
  logic            push_word;
  logic            will_be_full;

  logic            access;
  logic            hit;
  logic [1:0]      reg_sel;
  logic            wr_ctrl;
  logic            wr_status;
  logic            rd_data;
  logic            fifo_pop;
  logic            underflow_evt;
  logic [31:0]     rdata;
  logic [31:0]     crc_rdata;

  logic [31:0]     fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [LW-1:0]   fifo_level;

  logic            unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[30:16]};

  // Bus decode: a new access is one seen while ack is low
  assign access    = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign hit       = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = wbs_adr_i[3:2];
  assign wr_ctrl   = access && wbs_we_i && hit && (reg_sel == OFS_CTRL[3:2]);
  assign wr_status = access && wbs_we_i && hit && (reg_sel == OFS_STATUS[3:2]);
  assign rd_data   = access && !wbs_we_i && hit && (reg_sel == OFS_DATA[3:2]);
  assign fifo_pop      = rd_data && !fifo_empty;
  assign underflow_evt = rd_data && fifo_empty;

  // Capture datapath helpers
  assign push_due     = (remaining == 16'd1) || (bitpos == 5'd31);
  assign acc_with_bit = acc | (32'(shift_in) << bitpos);
  assign will_be_full = (fifo_level == LW'(FIFO_DEPTH - 1)) && !fifo_pop;
  assign push_word    = take_bit && push_due;

  // The chain only advances on cycles where a bit is actually taken
  assign shift_enable_o = take_bit;
  assign busy_o         = busy_q;

  config_readback_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push_word),
    .pop   (fifo_pop),
    .wdata (acc_with_bit),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state logic; a due push into a still-full FIFO holds the chain
  always_comb begin
    state_next   = state;
    take_bit     = 1'b0;
    accept_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_req && (ctrl_n != 16'd0)) begin
          accept_start = 1'b1;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (push_due && fifo_full) begin
          state_next = STALL;
        end else begin
          take_bit = 1'b1;
          if (remaining == 16'd1)                   state_next = FLUSH;
          else if (bitpos == 5'd31 && will_be_full) state_next = STALL;
        end
      end
      STALL: begin
        if (!fifo_full) state_next = SHIFT;
      end
      FLUSH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered busy flag
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
    end
  end

  // Bit counter, bit position and word accumulator
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      remaining <= '0;
      bitpos    <= '0;
      acc       <= '0;
    end else if (accept_start) begin
      remaining <= ctrl_n;
      bitpos    <= '0;
      acc       <= '0;
    end else if (take_bit) begin
      remaining <= remaining - 1'b1;
      if (push_due) begin
        bitpos <= '0;
        acc    <= '0;
      end else begin
        bitpos <= bitpos + 1'b1;
        acc    <= acc_with_bit;
      end
    end
  end

`ifdef CONFIG_READBACK_CRC_EN
  logic [15:0] crc;

  // CRC over every captured bit, reseeded when a capture starts
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)          crc <= '0;
    else if (accept_start) crc <= CRC_SEED;
    else if (take_bit)     crc <= crc16_step(crc, shift_in);
  end

  assign crc_rdata = {16'h0000, crc};
`else
  assign crc_rdata = 32'h0;
`endif

  // CTRL bit count and the start request handed to the FSM in the ack cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_n    <= '0;
      start_req <= 1'b0;
    end else begin
      start_req <= wr_ctrl && wbs_dat_i[CTRL_START_BIT];
      if (wr_ctrl) ctrl_n <= wbs_dat_i[15:0];
    end
  end

  // Sticky status bits; a set event in the same cycle wins over a clear
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      done          <= 1'b0;
      err_start     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (wr_status && wbs_dat_i[ST_DONE])          done          <= 1'b0;
      if (wr_status && wbs_dat_i[ST_ERR_START])     err_start     <= 1'b0;
      if (wr_status && wbs_dat_i[ST_ERR_UNDERFLOW]) err_underflow <= 1'b0;
      if (accept_start)                done          <= 1'b0;
      if (state == FLUSH)              done          <= 1'b1;
      if (start_req && state != IDLE)  err_start     <= 1'b1;
      if (underflow_evt)               err_underflow <= 1'b1;
    end
  end

  // Read multiplexer; undecoded addresses read 0
  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      unique case (reg_sel)
        OFS_CTRL[3:2]:   rdata = {16'h0000, ctrl_n};
        OFS_STATUS[3:2]: rdata = {24'h0, 4'(fifo_level), err_underflow, err_start, done, busy_q};
        OFS_DATA[3:2]:   rdata = fifo_empty ? 32'h0 : fifo_rdata;
        OFS_CRC[3:2]:    rdata = crc_rdata;
        default:         rdata = 32'h0;
      endcase
    end
  end

  // Registered single-cycle acknowledge with read data valid alongside it
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_config_readback.sv
// Self-checking bench for config_readback: a behavioural scan chain feeds
// random bit streams, and expected words, levels and CRC come from a model.
module tb_config_readback;

  localparam logic [31:0] BASE   = 32'h3000_1000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DATA = BASE + 32'h8;
  localparam logic [31:0] A_CRC  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic        shift_in = 1'b0;
  logic        shift_en;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic        chain_bits [512];
  int          chain_pos = 0;
  int          se_cycles = 0;
  logic        en_neg = 1'b0;
  logic [31:0] exp_q [$];

  config_readback #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wbs_cyc_i      (cyc),
    .wbs_stb_i      (stb),
    .wbs_we_i       (we),
    .wbs_sel_i      (sel),
    .wbs_adr_i      (adr),
    .wbs_dat_i      (dat_w),
    .wbs_ack_o      (ack),
    .wbs_dat_o      (dat_r),
    .shift_in       (shift_in),
    .shift_enable_o (shift_en),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural scan chain: advances one bit on each rising edge with enable high
  always @(negedge clk) en_neg = shift_en;
  always @(posedge clk) begin
    if (en_neg && !rst) begin
      #1;
      chain_pos = chain_pos + 1;
      se_cycles = se_cycles + 1;
      shift_in  = chain_bits[chain_pos];
    end
  end

  task automatic wb_access(input logic write, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd);
    int n;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = write; adr = addr; dat_w = wdata;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 20);
    rd = dat_r;
    if (!ack) begin
      checks++; errors++;
      $display("[TB] FAIL bus_ack addr=%h ack=%b required 1", addr, ack);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    wb_access(1'b1, addr, wdata, dummy);
  endtask

  task automatic wb_read(input logic [31:0] addr, output logic [31:0] rd);
    wb_access(1'b0, addr, 32'h0, rd);
  endtask

  // Reference packing: LSB-first, 32 bits per word, zero-padded last word
  task automatic build_expected(input int n);
    logic [31:0] w;
    exp_q.delete();
    for (int k = 0; k < (n + 31) / 32; k++) begin
      w = '0;
      for (int j = 0; j < 32; j++)
        if (32 * k + j < n) w[j] = chain_bits[32 * k + j];
      exp_q.push_back(w);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < 512; i++) chain_bits[i] = (i < n) ? 1'($urandom) : 1'b0;
  endtask

  task automatic start_capture(input int n);
    chain_pos = 0;
    se_cycles = 0;
    shift_in  = chain_bits[0];
    wb_write(A_CTRL, 32'h8000_0000 | 32'(n));
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy === 1'b1 && n < max_cycles) begin
      @(negedge clk); n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_idle_timeout busy=%b required 0", name, busy);
    end
  endtask

  task automatic drain_and_check(input string name);
    logic [31:0] rd;
    int idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      wb_read(A_DATA, rd);
      checks++;
      if (rd !== exp_q[0]) begin
        errors++;
        $display("[TB] FAIL %s_word%0d got=%h required=%h", name, idx, rd, exp_q[0]);
      end
      void'(exp_q.pop_front());
      idx++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack, shift_en, busy} !== 3'b000 || dat_r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs ack/se/busy=%b%b%b dat=%h required 000 0", ack, shift_en, busy, dat_r);
    end
    @(negedge clk); rst = 1'b0;
    wb_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_status got=%h required=0", rd); end
    wb_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_ctrl got=%h required=0", rd); end
    wb_read(A_CRC, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_crc got=%h required=0", rd); end
    wb_read(BASE + 32'h40, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL undecoded_read got=%h required=0", rd); end
  endtask

  task automatic test_single_word();
    logic [31:0] pat;
    logic [31:0] rd;
    pat = 32'hA5C3_0F81;
    for (int i = 0; i < 512; i++) chain_bits[i] = (i < 32) ? pat[i] : 1'b0;
    build_expected(32);
    start_capture(32);
    checks++;
    if (shift_en !== 1'b0) begin errors++; $display("[TB] FAIL start_latency_ack se=%b required 0", shift_en); end
    @(posedge clk); #1;
    checks++;
    if (shift_en !== 1'b1) begin errors++; $display("[TB] FAIL start_latency_next se=%b required 1", shift_en); end
    wait_idle(100, "single");
    checks++;
    if (se_cycles !== 32) begin errors++; $display("[TB] FAIL single_enable_cycles got=%0d required=32", se_cycles); end
    wb_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h12) begin errors++; $display("[TB] FAIL single_status got=%h required=12", rd); end
    wb_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h20) begin errors++; $display("[TB] FAIL ctrl_readback got=%h required=20", rd); end
    drain_and_check("single");
  endtask

  task automatic test_two_words();
    logic [31:0] rd;
    fill_random(40);
    build_expected(40);
    start_capture(40);
    wait_idle(100, "two");
    wb_read(A_STAT, rd);
    checks++;
    if (rd[7:4] !== 4'd2 || rd[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL two_status got=%h required level 2 done 1", rd);
    end
    drain_and_check("two");
  endtask

  task automatic test_random();
    logic [31:0] rd;
    int n;
    for (int it = 0; it < 3; it++) begin
      n = int'($urandom_range(1, 100));
      fill_random(n);
      build_expected(n);
      start_capture(n);
      wait_idle(200, "random");
      checks++;
      if (se_cycles !== n) begin errors++; $display("[TB] FAIL random_enable_cycles got=%0d required=%0d", se_cycles, n); end
      wb_read(A_STAT, rd);
      checks++;
      if (rd[7:4] !== 4'(exp_q.size())) begin
        errors++; $display("[TB] FAIL random_level got=%0d required=%0d", rd[7:4], exp_q.size());
      end
      drain_and_check("random");
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    fill_random(192);
    build_expected(192);
    start_capture(192);
    repeat (200) @(negedge clk);
    checks++;
    if (se_cycles !== 128 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_point se_cycles=%0d busy=%b required 128 1", se_cycles, busy);
    end
    wb_read(A_STAT, rd);
    checks++;
    if (rd[7:4] !== 4'd4 || rd[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_status got=%h required level 4 busy 1", rd);
    end
    for (int k = 0; k < 6; k++) begin
      repeat (50) @(negedge clk);
      wb_read(A_DATA, rd);
      checks++;
      if (rd !== exp_q[0]) begin
        errors++; $display("[TB] FAIL stall_word%0d got=%h required=%h", k, rd, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    wait_idle(100, "stall");
    checks++;
    if (se_cycles !== 192) begin errors++; $display("[TB] FAIL stall_total_bits got=%0d required=192", se_cycles); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    wb_write(A_STAT, 32'hE);
    fill_random(64);
    build_expected(64);
    start_capture(64);
    repeat (5) @(negedge clk);
    wb_write(A_CTRL, 32'h8000_0040);
    wb_read(A_STAT, rd);
    checks++;
    if (rd[2] !== 1'b1 || rd[0] !== 1'b1) begin errors++; $display("[TB] FAIL err_start got=%h required bit2 1 bit0 1", rd); end
    wait_idle(150, "errstart");
    checks++;
    if (se_cycles !== 64) begin errors++; $display("[TB] FAIL errstart_bits got=%0d required=64", se_cycles); end
    drain_and_check("errstart");
    wb_read(A_DATA, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL underflow_data got=%h required=0", rd); end
    wb_read(A_STAT, rd);
    checks++;
    if (rd[3] !== 1'b1) begin errors++; $display("[TB] FAIL underflow_flag got=%h required bit3 1", rd); end
    wb_write(A_STAT, 32'hE);
    wb_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL status_clear got=%h required=0", rd); end
    se_cycles = 0;
    wb_write(A_CTRL, 32'h8000_0000);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || se_cycles !== 0) begin
      errors++; $display("[TB] FAIL zero_start busy=%b se_cycles=%0d required 0 0", busy, se_cycles);
    end
  endtask

  task automatic test_crc();
    logic [31:0] rd;
    logic [31:0] exp_crc;
    logic [15:0] c;
    for (int i = 0; i < 512; i++) chain_bits[i] = (i < 32);
    build_expected(32);
    c = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      if ((c[15] ^ chain_bits[i]) == 1'b1) c = (c << 1) ^ 16'h1021;
      else                                 c = c << 1;
    end
`ifdef CONFIG_READBACK_CRC_EN
    exp_crc = {16'h0, c};
`else
    exp_crc = 32'h0;
`endif
    start_capture(32);
    wait_idle(100, "crc");
    wb_read(A_CRC, rd);
    checks++;
    if (rd !== exp_crc) begin errors++; $display("[TB] FAIL crc got=%h required=%h", rd, exp_crc); end
    drain_and_check("crc");
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int n;
    fill_random(64);
    start_capture(64);
    n = 0;
    while (chain_pos < 17 && n < 100) begin @(negedge clk); n++; end
    rst = 1'b1;
    #1;
    checks++;
    if (shift_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid se=%b busy=%b required 0 0", shift_en, busy);
    end
    @(negedge clk); rst = 1'b0;
    wb_read(A_STAT, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid_status got=%h required=0", rd); end
    wb_read(A_CRC, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid_crc got=%h required=0", rd); end
    wb_read(A_DATA, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid_data got=%h required=0", rd); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) chain_bits[i] = 1'b0;
    test_reset();
    test_single_word();
    test_two_words();
    test_random();
    test_stall();
    test_errors();
    test_crc();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_readback.md
# config_readback

Wishbone slave that captures the serial scan-out of the FPGA fabric configuration chain and returns it to the management core as 32-bit words. It is the receive end of the configuration shift chain: it drives the chain's shift enable, samples the last tile's serial output, and packs the bits into a small FIFO. Firmware uses it to verify a bitstream after programming. It sits in the user project wrapper next to the configuration writer, on the same Wishbone bus.

## Interface
- BASE_ADDR, 32'h3000_1000 — base address; the block decodes offsets 0x0–0xC.
- FIFO_DEPTH, 4 — word FIFO depth; a power of two, at least 2.
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset; asynchronous, active-high
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- shift_in  in  1  serial output of the last chain tile
- shift_enable_o  out  1  chain shift enable; the chain advances on each wb_clk_i rising edge where this is 1
- busy_o  out  1  capture in progress

## Operation
- Registers (offset from BASE_ADDR):
  - CTRL 0x0, RW: [15:0] bit count N; [31] start, write-only, reads 0.
  - STATUS 0x4: [0] busy; [1] done (sticky); [2] err_start (sticky); [3] err_underflow (sticky); [7:4] FIFO level. Writing 1 to bits 1–3 clears them.
  - DATA 0x8, RO: each read pops one FIFO word.
  - CRC 0xC, RO: see Configuration.
- FSM states: IDLE, SHIFT, STALL, FLUSH.
- IDLE:
  - A write to CTRL with start=1 and N>0 loads the bit counter with N, clears the accumulator and clears done, then moves to SHIFT.
  - A start with N=0 does nothing.
- SHIFT:
  - shift_enable_o=1.
  - Each cycle, the current shift_in is placed at accumulator bit index [bitpos] (LSB-first), then bitpos and the remaining-bit count update.
  - When bitpos reaches 32, or the last bit is taken, the word is pushed to the FIFO. A partial last word is zero-padded in its upper bits.
  - If a push is due and the FIFO will be full, go to STALL instead of taking more bits.
- STALL:
  - shift_enable_o=0; the chain holds its position.
  - Return to SHIFT on the cycle after a pop frees a slot. No bit is lost or duplicated.
- FLUSH:
  - Entered after the last push. Sets done, then returns to IDLE.
- A start while busy is ignored and sets err_start.
- Reading DATA when the FIFO is empty returns 0 and sets err_underflow; the FIFO pointers do not change.
- Any push and pop in the same cycle are both performed; the level is unchanged.
- Writes to read-only or undecoded offsets are acknowledged and have no effect. Undecoded reads return 0.

## Timing
- Reset: wbs_ack_o=0, wbs_dat_o=0, shift_enable_o=0, busy_o=0, FSM in IDLE, FIFO empty, all sticky bits 0, CTRL=0, CRC=0.
- A reset asserted mid-capture drops shift_enable_o immediately (asynchronous clear) and discards all captured data.
- Wishbone:
  - wbs_ack_o is a one-cycle registered pulse, the cycle after cyc&stb is seen while ack is low.
  - wbs_dat_o is valid in the ack cycle.
  - The FIFO pop happens in the ack cycle.
- Start latency: the start write is acked in cycle t; shift_enable_o=1 from cycle t+1.
- An uninterrupted N-bit capture keeps shift_enable_o high for exactly N cycles.
- A pushed word is readable on the next bus access.
- busy_o equals the STATUS busy bit (SHIFT, STALL or FLUSH) and is registered.

## Configuration
- CONFIG_READBACK_CRC_EN defined:
  - A CRC-16/CCITT register (polynomial 0x1021, seed 0xFFFF) updates once per captured bit.
  - It is reseeded at start.
  - CRC reads {16'h0, crc}.
- CONFIG_READBACK_CRC_EN undefined: no CRC logic is present and CRC reads 0.

## Structure
- config_readback_pkg holds:
  - register offsets
  - STATUS bit indices
  - the FSM state enum
  - CRC polynomial and seed
- Sub-module config_readback_fifo: synchronous FIFO with push, pop, full, empty and level outputs. It instantiates FIFO_DEPTH.

## Test plan
- N=32, shift_in driven by a pattern 0xA5C3_0F81 LSB-first → shift_enable_o high for exactly 32 cycles; DATA=0xA5C3_0F81; done=1.
- N=40 → two words; the second holds its 8 bits in [7:0] and zeros in [31:8]; FIFO level=2 before the reads.
- N=192 with no reads, FIFO_DEPTH=4 → STALL after the 4th push. Then read one word per 50 cycles → all 6 words intact and in order, with no missing bits.
- Start during busy → err_start=1, capture unaffected. Reading DATA while empty → returns 0, err_underflow=1. Write 0xE to STATUS → bits cleared.
- wb_rst_i pulsed at bit 17 of a 64-bit capture → shift_enable_o=0 in the same cycle; STATUS=0 afterwards.
- With CONFIG_READBACK_CRC_EN, N=32 of all ones → CRC matches the reference model value. Without it, CRC reads 0.
